clk_div_multi: RTL and testbench

//  Parametrised multi-channel clock/tick divider off the 100 MHz board clock.

---
 rtl/clk_div_multi.sv | 77 +++++++
 tb/tb_clk_div_multi.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick divider with shared phase-sync and shadowed divisors.
// Each channel emits a 50%-duty square wave and a one-cycle strobe every D+1 cycles.
module clk_div_multi #(
    parameter int unsigned      NUM_CH      = 4,
    parameter int unsigned      CNT_W       = 24,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = 24'h756013,
    localparam int unsigned     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              sync_i,
    input  logic              wr_en_i,
    input  logic [CH_W-1:0]   wr_ch_i,
    input  logic [CNT_W-1:0]  wr_data_i,
    output logic [NUM_CH-1:0] clkout_o,
    output logic [NUM_CH-1:0] tick_o
);

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] act_q, act_d;
    logic [NUM_CH-1:0][CNT_W-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0]            clkout_q, clkout_d;
    logic [NUM_CH-1:0]            tick_q, tick_d;
    logic                         wr_hit;

    // Out-of-range channel indices are dropped rather than aliased onto a real channel.
    assign wr_hit = wr_en_i && (32'(wr_ch_i) < NUM_CH);

    always_comb begin
        cnt_d    = cnt_q;
        act_d    = act_q;
        pend_d   = pend_q;
        clkout_d = clkout_q;
        tick_d   = tick_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (wr_hit && (32'(wr_ch_i) == i)) begin
                pend_d[i] = wr_data_i;
            end
            // act always samples the pre-write pend, so a same-edge write lands one period later.
            if (!en_i[i] || sync_i) begin
                cnt_d[i]    = '0;
                clkout_d[i] = 1'b0;
                tick_d[i]   = 1'b0;
                act_d[i]    = pend_q[i];
            end else if (cnt_q[i] == act_q[i]) begin
                cnt_d[i]    = '0;
                clkout_d[i] = ~clkout_q[i];
                tick_d[i]   = 1'b1;
                act_d[i]    = pend_q[i];
            end else begin
                cnt_d[i]  = cnt_q[i] + CNT_W'(1);
                tick_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            act_q    <= {NUM_CH{DEFAULT_DIV}};
            pend_q   <= {NUM_CH{DEFAULT_DIV}};
            clkout_q <= '0;
            tick_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
            clkout_q <= clkout_d;
            tick_q   <= tick_d;
        end
    end

    assign clkout_o = clkout_q;
    assign tick_o   = tick_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: per-cycle expected outputs are queued as stimulus is
// driven and compared on the falling edge once the DUT reaches that cycle.
module tb_clk_div_multi;

    localparam int unsigned NCH = 3;
    localparam int unsigned CW  = 8;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [NCH-1:0]  en;
    logic            sync;
    logic            wr_en;
    logic [1:0]      wr_ch;
    logic [CW-1:0]   wr_data;
    logic [NCH-1:0]  clkout;
    logic [NCH-1:0]  tick;

    clk_div_multi #(
        .NUM_CH     (NCH),
        .CNT_W      (CW),
        .DEFAULT_DIV(8'd5)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (en),
        .sync_i   (sync),
        .wr_en_i  (wr_en),
        .wr_ch_i  (wr_ch),
        .wr_data_i(wr_data),
        .clkout_o (clkout),
        .tick_o   (tick)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int   cyc;
        int   ch;
        logic tick;
        logic clk;
        int   tid;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tid = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].cyc <= cyc) begin
                check($sformatf("t%0d_ch%0d_c%0d_tick", sb[j].tid, sb[j].ch, sb[j].cyc),
                      32'(tick[sb[j].ch]), 32'(sb[j].tick));
                check($sformatf("t%0d_ch%0d_c%0d_clk", sb[j].tid, sb[j].ch, sb[j].cyc),
                      32'(clkout[sb[j].ch]), 32'(sb[j].clk));
                sb.delete(j);
            end
        end
    end

    task automatic push_one(input int ch, input int c, input logic t, input logic k);
        exp_t e;
        e.cyc  = c;
        e.ch   = ch;
        e.tick = t;
        e.clk  = k;
        e.tid  = tid;
        sb.push_back(e);
    endtask

    // Channel restarted with cnt=0 at cycle s, divisor d, square output clk0 at cycle s.
    task automatic push_seg(input int ch, input int s, input int d, input logic clk0, input int n);
        for (int c = s + 1; c <= s + n; c++) begin
            push_one(ch, c, ((c - s) % (d + 1)) == 0, clk0 ^ (((c - s) / (d + 1)) % 2 == 1));
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [CW-1:0] d);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_data = d;
        step(1);
        wr_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int k;
        int ticks;

        rst_ni  = 1'b0;
        en      = 3'b001;
        sync    = 1'b0;
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_data = '0;
        #3;
        check("reset_clk", 32'(clkout), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);

        // T1: release, run into the high phase, then reset asynchronously mid-period
        tid = 1;
        step(2);
        rst_ni = 1'b1;
        s = cyc;
        push_seg(0, s, 5, 1'b0, 8);
        wait_until(s + 8);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check("t1_async_clk", 32'(clkout), 32'd0);
        check("t1_async_tick", 32'(tick), 32'd0);
        step(1);
        rst_ni = 1'b1;
        s = cyc;
        push_seg(0, s, 5, 1'b0, 14);
        wait_until(s + 14);

        // T2: ch0 divisor 3 -> tick every 4, square 4 high / 4 low
        tid = 2;
        en[0] = 1'b0;
        wr(0, 8'd3);
        step(1);
        en[0] = 1'b1;
        s = cyc;
        push_seg(0, s, 3, 1'b0, 64);
        ticks = 0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            ticks += 32'(tick[0]);
        end
        check("t2_tick_count", 32'(ticks), 32'd16);

        // T3: shadowed divisor change mid-period on ch1
        tid = 3;
        wr(1, 8'd9);
        step(1);
        en[1] = 1'b1;
        s = cyc;
        push_seg(1, s, 9, 1'b0, 10);
        push_seg(1, s + 10, 2, 1'b1, 12);
        step(4);
        wr(1, 8'd2);
        wait_until(s + 23);

        // T4: sync realigns ch0 (D=3) and ch1 (D=5), then ch1 disabled
        tid = 4;
        wr(1, 8'd5);
        step(2);
        sync = 1'b1;
        k = cyc;
        push_one(0, k + 1, 1'b0, 1'b0);
        push_one(1, k + 1, 1'b0, 1'b0);
        push_seg(0, k + 1, 3, 1'b0, 23);
        push_seg(1, k + 1, 5, 1'b0, 12);
        step(1);
        sync = 1'b0;
        wait_until(k + 13);
        en[1] = 1'b0;
        for (int c = k + 14; c <= k + 24; c++) push_one(1, c, 1'b0, 1'b0);
        wait_until(k + 26);

        // T5a: D=0 on ch2
        tid = 5;
        wr(2, 8'd0);
        step(1);
        en[2] = 1'b1;
        s = cyc;
        push_seg(2, s, 0, 1'b0, 10);
        wait_until(s + 11);

        // T5b/c: out-of-range write ignored; write coinciding with terminal is deferred
        tid = 6;
        wr(2'd3, 8'd1);
        sync = 1'b1;
        s = cyc + 1;
        push_one(0, s, 1'b0, 1'b0);
        push_one(2, s, 1'b0, 1'b0);
        push_seg(0, s, 3, 1'b0, 8);
        push_seg(0, s + 8, 1, 1'b0, 8);
        push_seg(2, s, 0, 1'b0, 16);
        step(1);
        sync = 1'b0;
        wait_until(s + 3);
        wr(0, 8'd1);
        wait_until(s + 18);

        step(2);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
